mul_hilo_unit: RTL and testbench

MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

---
 rtl/mul_hilo_unit.sv | 136 +++++++++++++
 tb/tb_mul_hilo_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit
//   Iterative unsigned shift-add multiplier with an architectural HI/LO
//   register pair.  A MULTU code loads the operands and the unit runs one
//   shift-add step per clock for CYCLES clocks.  The product lands in HI/LO
//   either on the last step (if a HILO_WR was seen during the run or is
//   present on that edge) or later from the DONE state when HILO_WR arrives.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   Signal   6-bit function code from the ALU controller
//   dataA    multiplicand (unsigned)
//   dataB    multiplier (unsigned)
//   dataOut  combinational HI/LO read data (MFHI / MFLO, else 0)
//   HI, LO   upper / lower product halves
//   busy     high while a multiply is iterating
//   done     high while a finished product waits to be written
module mul_hilo_unit #(
   parameter int WIDTH  = 32,
   parameter int CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] dataOut,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done
);

   localparam logic [5:0] MULTU   = 6'b011001;
   localparam logic [5:0] HILO_WR = 6'b111111;
   localparam logic [5:0] MFHI    = 6'b010000;
   localparam logic [5:0] MFLO    = 6'b010010;
   localparam int         STEP_W  = $clog2(CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic [WIDTH-1:0]       mcand;
   logic [2*WIDTH-1:0]     prod;
   logic [STEP_W-1:0]      step;
   logic                   pending;
   logic [2*WIDTH-1:0]     prod_next;
   logic                   start;
   logic                   last_step;
   logic                   wr_now;

   // One shift-add iteration: conditionally add the multiplicand into the
   // upper half (keeping the carry) and shift the whole product right by one.
   function automatic logic [2*WIDTH-1:0] shift_add(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]};
      if (p[0])
         sum = sum + {1'b0, m};
      return {sum, p[WIDTH-1:1]};
   endfunction

   always_comb begin
      prod_next = shift_add(prod, mcand);
      start     = (Signal == MULTU) && ((state == IDLE) || (state == DONE));
      last_step = (step == STEP_W'(CYCLES - 1));
      wr_now    = (Signal == HILO_WR);
   end

   always_comb begin
      case (Signal)
         MFHI:    dataOut = HI;
         MFLO:    dataOut = LO;
         default: dataOut = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         HI      <= '0;
         LO      <= '0;
         mcand   <= '0;
         prod    <= '0;
         step    <= '0;
         pending <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         // A restart from DONE silently drops the unwritten product.
         mcand   <= dataA;
         prod    <= {{WIDTH{1'b0}}, dataB};
         step    <= '0;
         pending <= 1'b0;
         state   <= RUN;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               prod <= prod_next;
               step <= step + STEP_W'(1);
               if (wr_now)
                  pending <= 1'b1;
               if (last_step) begin
                  busy <= 1'b0;
                  if (pending || wr_now) begin
                     // Write straight from the final iteration result.
                     HI    <= prod_next[2*WIDTH-1:WIDTH];
                     LO    <= prod_next[WIDTH-1:0];
                     state <= IDLE;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (wr_now) begin
                  HI    <= prod[2*WIDTH-1:WIDTH];
                  LO    <= prod[WIDTH-1:0];
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            IDLE: ;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Testbench for mul_hilo_unit: directed scenarios plus randomized multiplies.
// Expected HI/LO values come from plain 64-bit multiplication and are queued
// when the write is requested; a monitor pops them when a run completes.
module tb_mul_hilo_unit;

   localparam logic [5:0] MULTU   = 6'b011001;
   localparam logic [5:0] HILO_WR = 6'b111111;
   localparam logic [5:0] MFHI    = 6'b010000;
   localparam logic [5:0] MFLO    = 6'b010010;
   localparam logic [5:0] ADD     = 6'b100000;
   localparam logic [5:0] NOP     = 6'b000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  Signal;
   logic [31:0] dataA, dataB;
   logic [31:0] dataOut, HI, LO;
   logic        busy, done;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;
   logic        prev_act = 1'b0;
   logic        done_seen;

   mul_hilo_unit #(.WIDTH(32), .CYCLES(32)) dut (
      .clk(clk), .reset(reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
      .dataOut(dataOut), .HI(HI), .LO(LO), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] p);
      exp_q.push_back(p);
      model_hi = p[63:32];
      model_lo = p[31:0];
   endtask

   // A run ends when busy/done both drop outside of reset; that is when HI/LO
   // must hold the oldest queued product.
   always @(negedge clk) begin
      logic [63:0] e;
      if (reset) begin
         prev_act = 1'b0;
      end else begin
         if (prev_act && !busy && !done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: HI=%0h LO=%0h with nothing queued", HI, LO);
            end else begin
               e = exp_q.pop_front();
               check("HI", 64'(HI), 64'(e[63:32]));
               check("LO", 64'(LO), 64'(e[31:0]));
            end
         end
         prev_act = busy || done;
      end
   end

   // mode 0: HILO_WR on the last step; 1: HILO_WR at wr_step (pending path);
   // 2: finish to DONE, then write; 3: finish to DONE and leave it there.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input int mode, input int wr_step, input bit poke);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      dataA  = a;
      dataB  = b;
      Signal = MULTU;
      tick();
      check("busy_after_load", 64'(busy), 64'(1));
      done_seen = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         Signal = NOP;
         if (poke && k == 5) begin
            Signal = MULTU;
            dataA  = $urandom;
            dataB  = $urandom;
         end
         if (mode == 1 && k == wr_step) begin
            Signal = HILO_WR;
            push(p);
         end
         if (mode == 0 && k == 32) begin
            Signal = HILO_WR;
            push(p);
         end
         if (k == 32)
            check("busy_before_last", 64'(busy), 64'(1));
         tick();
         if (done) done_seen = 1'b1;
      end
      Signal = NOP;
      if (mode <= 1) begin
         check("busy_after_last", 64'(busy), 64'(0));
         check("done_never", 64'(done_seen), 64'(0));
      end else begin
         check("done_held", 64'(done), 64'(1));
         check("HI_unchanged", 64'(HI), 64'(model_hi));
         check("LO_unchanged", 64'(LO), 64'(model_lo));
         if (mode == 2) begin
            repeat ($urandom_range(0, 3)) tick();
            check("done_still", 64'(done), 64'(1));
            Signal = HILO_WR;
            push(p);
            tick();
            Signal = NOP;
            check("done_cleared", 64'(done), 64'(0));
         end
      end
   endtask

   task automatic read_check(input string name, input logic [5:0] code, input logic [31:0] exp);
      Signal = code;
      #1;
      check(name, 64'(dataOut), 64'(exp));
      Signal = NOP;
   endtask

   initial begin
      reset  = 1'b1;
      Signal = NOP;
      dataA  = '0;
      dataB  = '0;
      tick();
      check("rst_HI", 64'(HI), 64'(0));
      check("rst_LO", 64'(LO), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      read_check("rst_dataOut", MFHI, 32'h0);
      @(negedge clk);
      #1 reset = 1'b0;

      // 3*5 left in DONE, then written.
      run_mul(32'd3, 32'd5, 2, 0, 1'b0);
      read_check("mflo_15", MFLO, 32'd15);

      // Largest operands, written on the final step.
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
      read_check("mfhi_max", MFHI, 32'hFFFF_FFFE);
      read_check("mflo_max", MFLO, 32'h0000_0001);

      // Pending write requested at step 20.
      run_mul($urandom, $urandom, 1, 20, 1'b0);

      // Product held in DONE then written; next one discarded by a restart.
      run_mul($urandom, $urandom, 2, 0, 1'b0);
      run_mul($urandom, $urandom, 3, 0, 1'b0);
      run_mul(32'd7, 32'd9, 0, 0, 1'b0);
      read_check("mflo_63", MFLO, 32'd63);

      // Reset in the middle of a run.
      dataA  = 32'h1234_5678;
      dataB  = 32'h9ABC_DEF0;
      Signal = MULTU;
      tick();
      Signal = MFHI;
      repeat (10) tick();
      #2 reset = 1'b1;
      #1;
      check("abort_HI", 64'(HI), 64'(0));
      check("abort_LO", 64'(LO), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_dataOut", 64'(dataOut), 64'(0));
      model_hi = '0;
      model_lo = '0;
      Signal   = NOP;
      @(negedge clk);
      #1 reset = 1'b0;
      run_mul(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1'b0);
      read_check("rerun_HI", MFHI, 32'h0B00_EA4E);
      read_check("rerun_LO", MFLO, 32'h242D_2080);

      // Zero operand with a stray MULTU mid-run.
      run_mul(32'h0, 32'hFFFF_FFFF, 0, 0, 1'b1);
      read_check("zero_HI", MFHI, 32'h0);
      read_check("add_dataOut", ADD, 32'h0);

      // Randomized runs over all completion paths.
      for (int i = 0; i < 20; i++)
         run_mul($urandom, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d writes outstanding, 0 required", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
